csm_nport_ctrl: RTL and testbench

N-port shared-memory controller; synthesizable successor of the two-processor (A/B) CSM, generalised to NUM_PORTS processors. Each port uses the same multiplexed address/data bus protocol: enable/rw/hold/release in, ack/err/out_data out. A round-robin arbiter serialises access to one DEPTH x DATABITS memory and a single exclusive lock, acquired with hold and freed with release. Sits between the processor-side BFMs/agents and the memory array.

---
 rtl/csm_nport_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_csm_nport_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/csm_nport_ctrl.sv
// N-port shared-memory controller: per-port command FSMs, round-robin grant of one request per cycle,
// single exclusive lock. Define CSM_LOCK_WAIT_EN to make locked-out requests wait instead of failing.
module csm_nport_ctrl #(
  parameter int NUM_PORTS = 2,
  parameter int DATABITS  = 8,
  parameter int ERRBITS   = 2,
  parameter int DEPTH     = 256,
  localparam int LW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS*DATABITS-1:0]   p_in_ad,
  input  logic [NUM_PORTS-1:0]            p_rw,
  input  logic [NUM_PORTS-1:0]            p_enable,
  input  logic [NUM_PORTS-1:0]            p_hold,
  input  logic [NUM_PORTS-1:0]            p_release,
  output logic [NUM_PORTS-1:0]            p_ack,
  output logic [NUM_PORTS*ERRBITS-1:0]    p_err,
  output logic [NUM_PORTS*DATABITS-1:0]   p_out_data,
  output logic                            lock_valid,
  output logic [LW-1:0]                   lock_owner
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATABITS:0]  DEPTH_V  = (DATABITS+1)'(DEPTH);
  localparam logic [ERRBITS-1:0] E_OK     = ERRBITS'(0);
  localparam logic [ERRBITS-1:0] E_LOCKED = ERRBITS'(1);
  localparam logic [ERRBITS-1:0] E_NOWN   = ERRBITS'(2);
  localparam logic [ERRBITS-1:0] E_RANGE  = ERRBITS'(3);

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_REQ} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_HOLD, OP_REL} op_t;

  function automatic op_t f_dec(input logic h, input logic r, input logic w);
    if (h) return OP_HOLD;
    if (r) return OP_REL;
    if (w) return OP_WR;
    return OP_RD;
  endfunction

  state_t r_state [NUM_PORTS];
  state_t w_nstate[NUM_PORTS];
  op_t    r_op    [NUM_PORTS];

  logic [NUM_PORTS-1:0][DATABITS-1:0] w_ad;
  logic [NUM_PORTS-1:0][DATABITS-1:0] r_addr, r_data, r_out;
  logic [NUM_PORTS-1:0][ERRBITS-1:0]  r_err;
  logic [DATABITS-1:0]                r_mem [DEPTH];
  logic                               r_lock_vld;
  logic [LW-1:0]                      r_lock_own, r_rr;

  logic [NUM_PORTS-1:0] w_elig;
  logic                 w_gnt_vld;
  logic [LW-1:0]        w_gnt;
  logic [LW:0]          w_cand;
  op_t                  w_op;
  logic [DATABITS-1:0]  w_addr, w_wdat, w_rdat;
  logic [ERRBITS-1:0]   w_err;
  logic                 w_we, w_lk_set, w_lk_clr, w_own_ok, w_in_rng;

  assign w_ad       = p_in_ad;
  assign p_err      = r_err;
  assign p_out_data = r_out;
  assign lock_valid = r_lock_vld;
  assign lock_owner = r_lock_own;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) p_ack[p] = (r_state[p] == S_IDLE);
  end

  // A port waiting in REQ may be held off while another port owns the lock.
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_elig[p] = (r_state[p] == S_REQ);
`ifdef CSM_LOCK_WAIT_EN
      if (r_op[p] != OP_REL && r_lock_vld && r_lock_own != LW'(p)) w_elig[p] = 1'b0;
`endif
    end
  end

  // Round-robin: search starts at r_rr (the port after the last grant).
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_cand = {1'b0, r_rr} + (LW+1)'(k);
      if (w_cand >= (LW+1)'(NUM_PORTS)) w_cand = w_cand - (LW+1)'(NUM_PORTS);
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!w_gnt_vld && w_elig[p] && w_cand == (LW+1)'(p)) begin
          w_gnt_vld = 1'b1;
          w_gnt     = LW'(p);
        end
      end
    end
  end

  always_comb begin
    w_op     = r_op[w_gnt];
    w_addr   = r_addr[w_gnt];
    w_wdat   = r_data[w_gnt];
    w_in_rng = ({1'b0, w_addr} < DEPTH_V);
    w_own_ok = !r_lock_vld || (r_lock_own == w_gnt);
    w_err    = E_OK;
    w_rdat   = '0;
    w_we     = 1'b0;
    w_lk_set = 1'b0;
    w_lk_clr = 1'b0;
    case (w_op)
      OP_HOLD: if (w_own_ok) w_lk_set = 1'b1; else w_err = E_LOCKED;
      OP_REL:  if (r_lock_vld && r_lock_own == w_gnt) w_lk_clr = 1'b1; else w_err = E_NOWN;
      default: begin
        if (!w_own_ok)          w_err  = E_LOCKED;
        else if (!w_in_rng)     w_err  = E_RANGE;
        else if (w_op == OP_WR) w_we   = 1'b1;
        else                    w_rdat = r_mem[w_addr[AW-1:0]];
      end
    endcase
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_nstate[p] = r_state[p];
      case (r_state[p])
        S_IDLE:  if (p_enable[p])
                   w_nstate[p] = (f_dec(p_hold[p], p_release[p], p_rw[p]) == OP_WR) ? S_WDATA : S_REQ;
        S_WDATA: w_nstate[p] = S_REQ;
        S_REQ:   if (w_gnt_vld && w_gnt == LW'(p)) w_nstate[p] = S_IDLE;
        default: w_nstate[p] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) r_state[p] <= S_IDLE;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) r_state[p] <= w_nstate[p];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) r_op[p] <= OP_RD;
      r_addr     <= '0;
      r_data     <= '0;
      r_err      <= '0;
      r_out      <= '0;
      r_lock_vld <= 1'b0;
      r_lock_own <= '0;
      r_rr       <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (r_state[p] == S_IDLE && p_enable[p]) begin
          r_addr[p] <= w_ad[p];
          r_op[p]   <= f_dec(p_hold[p], p_release[p], p_rw[p]);
        end
        if (r_state[p] == S_WDATA) r_data[p] <= w_ad[p];
      end
      if (w_gnt_vld) begin
        r_err[w_gnt] <= w_err;
        r_out[w_gnt] <= w_rdat;
        r_rr         <= (w_gnt == LW'(NUM_PORTS-1)) ? '0 : w_gnt + LW'(1);
        if (w_lk_set) begin
          r_lock_vld <= 1'b1;
          r_lock_own <= w_gnt;
        end
        if (w_lk_clr) begin
          r_lock_vld <= 1'b0;
          r_lock_own <= '0;
        end
      end
    end
  end

  // Array is not reset; reset_n gate keeps an in-flight grant from writing as reset asserts.
  always_ff @(posedge clk) begin
    if (reset_n && w_gnt_vld && w_we) r_mem[w_addr[AW-1:0]] <= w_wdat;
  end
endmodule

// File: tb/tb_csm_nport_ctrl.sv
// Directed bench for csm_nport_ctrl (3 ports, DEPTH 200) with a transaction-level reference model.
module tb_csm_nport_ctrl;
  localparam int NP = 3, DB = 8, EB = 2, DP = 200;
  localparam int K_RD = 0, K_WR = 1, K_HOLD = 2, K_REL = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [NP-1:0][DB-1:0] ad;
  logic [NP-1:0] rw, en, hd, rl;
  logic [NP-1:0] ack;
  logic [NP-1:0][EB-1:0] err;
  logic [NP-1:0][DB-1:0] od;
  logic lv;
  logic [1:0] lo;

  int checks = 0, errors = 0;

  csm_nport_ctrl #(.NUM_PORTS(NP), .DATABITS(DB), .ERRBITS(EB), .DEPTH(DP)) dut (
    .clk(clk), .reset_n(reset_n), .p_in_ad(ad), .p_rw(rw), .p_enable(en),
    .p_hold(hd), .p_release(rl), .p_ack(ack), .p_err(err), .p_out_data(od),
    .lock_valid(lv), .lock_owner(lo));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each port is idle(0) / awaiting data(1) / pending(2); one pending port served per edge.
  int m_ph[NP], m_op[NP], m_a[NP], m_d[NP], m_err[NP], m_out[NP];
  int m_lk = -1, m_rr = 0, m_g;
  int m_mem[256];

  function automatic bit m_can(int p);
`ifdef CSM_LOCK_WAIT_EN
    return !(m_op[p] != K_REL && m_lk >= 0 && m_lk != p);
`else
    return 1'b1;
`endif
  endfunction

  task automatic m_serve(input int g);
    int e, o;
    e = 0; o = 0;
    if (m_op[g] == K_HOLD) begin
      if (m_lk < 0 || m_lk == g) m_lk = g; else e = 1;
    end else if (m_op[g] == K_REL) begin
      if (m_lk == g) m_lk = -1; else e = 2;
    end else if (m_lk >= 0 && m_lk != g) e = 1;
    else if (m_a[g] >= DP) e = 3;
    else if (m_op[g] == K_WR) m_mem[m_a[g]] = m_d[g];
    else o = m_mem[m_a[g]];
    m_err[g] = e;
    m_out[g] = o;
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      m_ph[p] = 0; m_op[p] = 0; m_a[p] = 0; m_d[p] = 0; m_err[p] = 0; m_out[p] = 0;
    end
    for (int i = 0; i < 256; i++) m_mem[i] = 0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NP; p++) begin
        m_ph[p] = 0; m_err[p] = 0; m_out[p] = 0;
      end
      m_lk = -1; m_rr = 0;
    end else begin
      m_g = -1;
      for (int i = 0; i < NP; i++)
        if (m_g < 0 && m_ph[(m_rr+i)%NP] == 2 && m_can((m_rr+i)%NP)) m_g = (m_rr+i)%NP;
      for (int p = 0; p < NP; p++) begin
        if (m_ph[p] == 1) begin
          m_d[p] = int'(ad[p]); m_ph[p] = 2;
        end else if (m_ph[p] == 0 && en[p]) begin
          m_a[p]  = int'(ad[p]);
          m_op[p] = hd[p] ? K_HOLD : rl[p] ? K_REL : rw[p] ? K_WR : K_RD;
          m_ph[p] = (m_op[p] == K_WR) ? 1 : 2;
        end
      end
      if (m_g >= 0) begin
        m_serve(m_g);
        m_ph[m_g] = 0;
        m_rr = (m_g + 1) % NP;
      end
    end
  end

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("ack%0d", p), 32'(ack[p]), 32'(m_ph[p] == 0));
      chk($sformatf("err%0d", p), 32'(err[p]), 32'(m_err[p]));
      chk($sformatf("out%0d", p), 32'(od[p]), 32'(m_out[p]));
    end
    chk("lock_valid", 32'(lv), 32'(m_lk >= 0));
    chk("lock_owner", 32'(lo), 32'((m_lk < 0) ? 0 : m_lk));
  end

  task automatic set_cmd(input int p, input int k, input logic [7:0] a);
    en[p] = 1'b1; rw[p] = (k == K_WR); hd[p] = (k == K_HOLD); rl[p] = (k == K_REL); ad[p] = a;
  endtask

  task automatic clr(input int p);
    en[p] = 1'b0; rw[p] = 1'b0; hd[p] = 1'b0; rl[p] = 1'b0;
  endtask

  task automatic go(input int p, input int k, input logic [7:0] a, input logic [7:0] d);
    set_cmd(p, k, a);
    @(negedge clk);
    clr(p);
    if (k == K_WR) ad[p] = d;
  endtask

  task automatic wait_ack(input int p, output int lat);
    lat = 0;
    while (ack[p] !== 1'b1 && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    if (lat >= 40) begin
      checks++; errors++;
      $display("FAIL timeout port%0d ack still low", p);
    end
  endtask

  task automatic run1(input int p, input int k, input logic [7:0] a, input logic [7:0] d, output int lat);
    go(p, k, a, d);
    wait_ack(p, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    en = '0; rw = '0; hd = '0; rl = '0; ad = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h7);
    chk("rst_lv", 32'(lv), 0);
    chk("rst_od", 32'(od), 0);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // write then read back, latencies 2 and 1
    run1(0, K_WR, 8'h10, 8'hA5, lat); chk("wr_lat", lat, 2);
    run1(1, K_RD, 8'h10, 8'h00, lat); chk("rd_lat", lat, 1);
    chk("rd_data", 32'(od[1]), 32'hA5);
    chk("rd_err", 32'(err[1]), 0);

    // contention: port0 first, port1 next cycle
    set_cmd(0, K_RD, 8'h10); set_cmd(1, K_RD, 8'h10);
    @(negedge clk); clr(0); clr(1);
    @(negedge clk); chk("c1_ack0", 32'(ack[0]), 1); chk("c1_ack1", 32'(ack[1]), 0);
    @(negedge clk); chk("c1_ack1b", 32'(ack[1]), 1); chk("c1_out1", 32'(od[1]), 32'hA5);
    // after a solo port0 grant, the next contention favours port1
    run1(0, K_RD, 8'h10, 8'h00, lat);
    set_cmd(0, K_RD, 8'h10); set_cmd(1, K_RD, 8'h10);
    @(negedge clk); clr(0); clr(1);
    @(negedge clk); chk("c2_ack1", 32'(ack[1]), 1); chk("c2_ack0", 32'(ack[0]), 0);
    @(negedge clk); chk("c2_ack0b", 32'(ack[0]), 1);

    // lock interaction with a foreign write
    run1(0, K_WR, 8'h20, 8'h33, lat);
    run1(1, K_HOLD, 8'h00, 8'h00, lat);
    chk("hold_lv", 32'(lv), 1); chk("hold_lo", 32'(lo), 1); chk("hold_err", 32'(err[1]), 0);
`ifdef CSM_LOCK_WAIT_EN
    go(0, K_WR, 8'h20, 8'h77);
    repeat (4) @(negedge clk);
    chk("wait_ack0", 32'(ack[0]), 0);
    run1(1, K_REL, 8'h00, 8'h00, lat);
    wait_ack(0, lat);
    chk("wait_err0", 32'(err[0]), 0);
    run1(0, K_RD, 8'h20, 8'h00, lat);
    chk("wait_mem", 32'(od[0]), 32'h77);
`else
    run1(0, K_WR, 8'h20, 8'h77, lat);
    chk("lk_lat", lat, 2); chk("lk_err", 32'(err[0]), 1);
    run1(1, K_REL, 8'h00, 8'h00, lat);
    chk("rel_lv", 32'(lv), 0);
    run1(0, K_RD, 8'h20, 8'h00, lat);
    chk("lk_mem", 32'(od[0]), 32'h33);
`endif

    // release rules
    run1(0, K_REL, 8'h00, 8'h00, lat); chk("rel_free", 32'(err[0]), 2);
    run1(1, K_HOLD, 8'h00, 8'h00, lat);
    run1(0, K_REL, 8'h00, 8'h00, lat); chk("rel_nown", 32'(err[0]), 2); chk("rel_nown_lv", 32'(lv), 1);
    run1(1, K_REL, 8'h00, 8'h00, lat); chk("rel_ok", 32'(err[1]), 0); chk("rel_ok_lv", 32'(lv), 0);

    // simultaneous holds: last grant was port1, so port2 wins
    set_cmd(0, K_HOLD, 8'h00); set_cmd(2, K_HOLD, 8'h00);
    @(negedge clk); clr(0); clr(2);
`ifdef CSM_LOCK_WAIT_EN
    repeat (3) @(negedge clk);
    chk("hh_lo", 32'(lo), 2); chk("hh_ack0", 32'(ack[0]), 0);
    run1(2, K_REL, 8'h00, 8'h00, lat);
    wait_ack(0, lat);
    chk("hh_lo0", 32'(lo), 0); chk("hh_lv0", 32'(lv), 1);
    run1(0, K_REL, 8'h00, 8'h00, lat);
`else
    @(negedge clk); @(negedge clk);
    chk("hh_lo", 32'(lo), 2); chk("hh_lv", 32'(lv), 1);
    chk("hh_err0", 32'(err[0]), 1); chk("hh_err2", 32'(err[2]), 0);
    run1(2, K_REL, 8'h00, 8'h00, lat);
`endif

    // address range edges at DEPTH=200
    run1(0, K_RD, 8'hC8, 8'h00, lat); chk("rng_err", 32'(err[0]), 3); chk("rng_out", 32'(od[0]), 0);
    run1(1, K_WR, 8'hFF, 8'h12, lat); chk("rng_werr", 32'(err[1]), 3);
    run1(1, K_WR, 8'hC7, 8'h5A, lat); chk("top_werr", 32'(err[1]), 0);
    run1(0, K_RD, 8'hC7, 8'h00, lat); chk("top_rd", 32'(od[0]), 32'h5A);

    // reset during a write data cycle
    run1(0, K_WR, 8'h30, 8'h11, lat);
    run1(1, K_HOLD, 8'h00, 8'h00, lat);
    go(0, K_WR, 8'h30, 8'h99);
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("mid_ack", 32'(ack), 32'h7); chk("mid_lv", 32'(lv), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    run1(0, K_RD, 8'h30, 8'h00, lat); chk("mid_mem", 32'(od[0]), 32'h11);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
